risc_sequencer: RTL and testbench
=================================

Name: risc_sequencer

Overview:
- Eight-phase control sequencer for the accumulator CPU built around the 3-bit-opcode ALU (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP).
- Steps through fetch/decode/execute phases and drives the memory, IR, PC and accumulator strobes from the phase, the current IR opcode and the ALU zero flag.
- Adds a run/stall input for single-step debug and a sticky halt state.

Parameters:
- OPC_WIDTH, 3, opcode width; fixed by the ALU encoding, not overridable in practice.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- opcode  input  OPC_WIDTH  opcode field of the instruction register; stable from phase 3 onward.
- zero  input  1  ALU a_is_zero (accumulator == 0).
- run  input  1  1 = free-run; 0 = stall at the next INST_ADDR.
- sel  output  1  address mux: 1 = PC, 0 = IR operand.
- rd  output  1  memory read enable.
- ld_ir  output  1  instruction register load.
- inc_pc  output  1  PC increment.
- ld_pc  output  1  PC load (jump).
- ld_ac  output  1  accumulator load.
- data_e  output  1  accumulator drive onto data bus.
- wr  output  1  memory write strobe.
- halt  output  1  processor halted (sticky).
- instr_done  output  1  one-cycle pulse in the final phase of each executed instruction.
- retired  output  CNT_WIDTH  count of completed instructions, wraps modulo 2^CNT_WIDTH.

Behaviour:
- State: 3-bit phase register plus a sticky halted flag. Phases 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Sequencing: phase advances by 1 each cycle and wraps 7 -> 0.
- Stall: in INST_ADDR with run=0, phase holds at 0. Phase leaves 0 on the first cycle run=1. run is sampled only in phase 0; deasserting it mid-instruction does not stall.
- Halt: halted sets at the clock edge ending OP_ADDR when opcode=HLT. Once set, phase freezes at 4, all strobes are 0, halt=1, and only rst clears it.
- Decode: outputs are combinational from the registered phase, halted, opcode and zero. ALUOP = ADD|AND|XOR|LDA.
  - Phase 0: sel=1.
  - Phase 1: sel=1, rd=1.
  - Phase 2: sel=1, rd=1, ld_ir=1.
  - Phase 3: sel=1, rd=1, ld_ir=1.
  - Phase 4: inc_pc=1; halt=1 if opcode=HLT.
  - Phase 5: rd=ALUOP.
  - Phase 6: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - Phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO; instr_done=1.
  - All signals not listed for a phase are 0.
- Counter: retired increments on every cycle where instr_done=1 and wraps from all-ones to 0.
- Reset: rst takes priority over everything, including mid-instruction and while halted. Next cycle: phase=0, halted=0, retired=0, so outputs are sel=1, everything else 0.
- Simultaneous events: rst together with an HLT decode resolves to reset. In phase 0, run=0 and rst=1 gives reset, then holds phase 0.
- Guarantees: wr and rd are never high in the same cycle. ld_pc and inc_pc are never high in the same cycle.

Decomposition:
- Shared package (risc_pkg):
  - Opcode localparams OP_HLT=0, OP_SKZ=1, OP_ADD=2, OP_AND=3, OP_XOR=4, OP_LDA=5, OP_STO=6, OP_JMP=7.
  - Phase localparams PH_INST_ADDR..PH_STORE.
  - The ALU reuses the opcode constants.
- One sub-module, risc_ctrl_decode: purely combinational mapping of (phase, opcode, zero, halted) to the strobe vector, so the decode table is unit-testable on its own.
- Phase counter, halt flag, run stall and retired counter stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles, run=1 -> sel=1, all other outputs 0, retired=0. First post-reset cycles show phase 0,1,2 with rd=1 in phases 1 and 2.
- ADD: opcode=2 over one instruction -> rd=1 in phases 5-7, ld_ac=1 only in phase 7, instr_done pulses once, retired 0 -> 1. STO (opcode=6) -> data_e in phases 6-7, wr only in phase 7, rd=0 in phases 5-7.
- SKZ with zero=1 -> inc_pc=1 in phases 4 and 6. With zero=0 -> inc_pc only in phase 4. JMP (opcode=7) -> ld_pc in phases 6-7.
- HLT: opcode=0 -> halt=1 in phase 4, then halt stays 1 and all strobes 0 for 20 cycles. retired unchanged. rst=1 -> restart at phase 0.
- Run stall: run=0 at phase 0 for 5 cycles -> sel=1, no other strobes, phase held. run=1 -> phase 1 next cycle. Dropping run in phase 3 -> instruction completes through phase 7, then stalls at phase 0.
- Wrap and reset: CNT_WIDTH=4, 17 instructions -> retired = 1. rst asserted in phase 6 of an STO -> no wr pulse; next cycle is phase 0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared constants and types for the accumulator CPU: opcodes, sequencer phases
// and the control strobe bundle produced by the phase decoder.
package risc_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic data_e;
        logic wr;
        logic halt;
        logic instr_done;
    } strobes_t;

    // Instructions that read an operand from memory into the accumulator path.
    function automatic logic is_aluop(input logic [2:0] opc);
        return (opc == OP_ADD) || (opc == OP_AND) || (opc == OP_XOR) || (opc == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational phase decoder: maps (phase, opcode, zero, halted) onto the
// control strobe bundle. Holds no state.
module risc_ctrl_decode
    import risc_pkg::*;
#(
    parameter int unsigned OPC_WIDTH = 3
) (
    input  logic [2:0]           phase,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 zero,
    input  logic                 halted,
    output strobes_t             strobes
);

    logic [2:0] opc;
    logic       aluop;

    assign opc   = opcode[2:0];
    assign aluop = is_aluop(opc);

    always_comb begin
        strobes = '0;
        if (halted) begin
            strobes.halt = 1'b1;
        end else begin
            unique case (phase)
                PH_INST_ADDR: begin
                    strobes.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    strobes.sel = 1'b1;
                    strobes.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    strobes.sel   = 1'b1;
                    strobes.rd    = 1'b1;
                    strobes.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    strobes.inc_pc = 1'b1;
                    strobes.halt   = (opc == OP_HLT);
                end
                PH_OP_FETCH: begin
                    strobes.rd = aluop;
                end
                PH_ALU_OP: begin
                    strobes.rd     = aluop;
                    strobes.inc_pc = (opc == OP_SKZ) && zero;
                    strobes.ld_pc  = (opc == OP_JMP);
                    strobes.data_e = (opc == OP_STO);
                end
                PH_STORE: begin
                    strobes.rd         = aluop;
                    strobes.ld_ac      = aluop;
                    strobes.ld_pc      = (opc == OP_JMP);
                    strobes.wr         = (opc == OP_STO);
                    strobes.data_e     = (opc == OP_STO);
                    strobes.instr_done = 1'b1;
                end
                default: strobes = '0;
            endcase
        end
    end

endmodule

// File: rtl/risc_sequencer.sv
// Eight-phase control sequencer: phase counter with run stall, sticky halt flag
// and retired-instruction counter around the combinational strobe decoder.
module risc_sequencer
    import risc_pkg::*;
#(
    parameter int unsigned OPC_WIDTH = 3,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 zero,
    input  logic                 run,
    output logic                 sel,
    output logic                 rd,
    output logic                 ld_ir,
    output logic                 inc_pc,
    output logic                 ld_pc,
    output logic                 ld_ac,
    output logic                 data_e,
    output logic                 wr,
    output logic                 halt,
    output logic                 instr_done,
    output logic [CNT_WIDTH-1:0] retired
);

    logic [2:0]           phase_q, phase_d;
    logic                 halted_q, halted_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    strobes_t             strobes;

    risc_ctrl_decode #(
        .OPC_WIDTH (OPC_WIDTH)
    ) u_decode (
        .phase   (phase_q),
        .opcode  (opcode),
        .zero    (zero),
        .halted  (halted_q),
        .strobes (strobes)
    );

    always_comb begin
        phase_d   = phase_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (halted_q) begin
            phase_d = phase_q;
        end else if (phase_q == PH_INST_ADDR && !run) begin
            phase_d = phase_q;
        end else if (phase_q == PH_OP_ADDR && opcode[2:0] == OP_HLT) begin
            // Freeze in OP_ADDR; only reset leaves the halted state.
            halted_d = 1'b1;
        end else begin
            phase_d = phase_q + 3'd1;
        end
        if (strobes.instr_done) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_INST_ADDR;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            phase_q   <= phase_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign sel        = strobes.sel;
    assign rd         = strobes.rd;
    assign ld_ir      = strobes.ld_ir;
    assign inc_pc     = strobes.inc_pc;
    assign ld_pc      = strobes.ld_pc;
    assign ld_ac      = strobes.ld_ac;
    assign data_e     = strobes.data_e;
    assign wr         = strobes.wr;
    assign halt       = strobes.halt;
    assign instr_done = strobes.instr_done;
    assign retired    = retired_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Directed self-checking bench for risc_sequencer; a second instance with a
// 4-bit counter shares the stimulus to exercise retired-count wrap.
module tb_risc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  opcode;
    logic        zero;
    logic        run;

    logic        sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, instr_done;
    logic [15:0] retired;
    logic        sel4, rd4, ld_ir4, inc_pc4, ld_pc4, ld_ac4, data_e4, wr4, halt4, done4;
    logic [3:0]  retired4;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ret = 0;

    // {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, instr_done}
    localparam logic [9:0] V_P0   = 10'b1000000000;
    localparam logic [9:0] V_P1   = 10'b1100000000;
    localparam logic [9:0] V_P23  = 10'b1110000000;
    localparam logic [9:0] V_P4   = 10'b0001000000;
    localparam logic [9:0] V_P4H  = 10'b0001000010;
    localparam logic [9:0] V_NONE = 10'b0000000000;
    localparam logic [9:0] V_HALT = 10'b0000000010;

    always #5 clk = ~clk;

    risc_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .run        (run),
        .sel        (sel),
        .rd         (rd),
        .ld_ir      (ld_ir),
        .inc_pc     (inc_pc),
        .ld_pc      (ld_pc),
        .ld_ac      (ld_ac),
        .data_e     (data_e),
        .wr         (wr),
        .halt       (halt),
        .instr_done (instr_done),
        .retired    (retired)
    );

    risc_sequencer #(
        .CNT_WIDTH (4)
    ) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .run        (run),
        .sel        (sel4),
        .rd         (rd4),
        .ld_ir      (ld_ir4),
        .inc_pc     (inc_pc4),
        .ld_pc      (ld_pc4),
        .ld_ac      (ld_ac4),
        .data_e     (data_e4),
        .wr         (wr4),
        .halt       (halt4),
        .instr_done (done4),
        .retired    (retired4)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, instr_done};
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %b required %b", tag, obs, exp);
        end
        n_tests++;
        assert (!(rd && wr) && !(ld_pc && inc_pc))
        else begin
            n_fail++;
            $error("FAIL %s_excl: got rd/wr=%b%b ld_pc/inc_pc=%b%b required no overlap",
                   tag, rd, wr, ld_pc, inc_pc);
        end
    endtask

    task automatic chk_ret(input string tag);
        n_tests++;
        assert (retired === 16'(exp_ret) && retired4 === 4'(exp_ret))
        else begin
            n_fail++;
            $error("FAIL %s: got %0d/%0d required %0d/%0d", tag, retired, retired4,
                   16'(exp_ret), 4'(exp_ret));
        end
    endtask

    // Starts at the phase-0 sample point, ends at the next instruction's phase 0.
    task automatic instr(input string tag, input logic [2:0] opc, input logic z,
                         input logic [9:0] e5, input logic [9:0] e6, input logic [9:0] e7);
        opcode = opc;
        zero   = z;
        chk({tag, "_p0"}, V_P0);
        tick; chk({tag, "_p1"}, V_P1);
        tick; chk({tag, "_p2"}, V_P23);
        tick; chk({tag, "_p3"}, V_P23);
        tick; chk({tag, "_p4"}, V_P4);
        tick; chk({tag, "_p5"}, e5);
        tick; chk({tag, "_p6"}, e6);
        tick; chk({tag, "_p7"}, e7);
        tick;
        exp_ret++;
        chk_ret({tag, "_ret"});
    endtask

    initial begin
        rst    = 1'b1;
        run    = 1'b1;
        opcode = 3'd2;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", V_P0);
        chk_ret("reset_ret");
        rst = 1'b0;

        instr("add", 3'd2, 1'b0, 10'b0100000000, 10'b0100000000, 10'b0100010001);
        instr("sto", 3'd6, 1'b0, V_NONE, 10'b0000001000, 10'b0000001101);
        instr("skz1", 3'd1, 1'b1, V_NONE, 10'b0001000000, 10'b0000000001);
        instr("skz0", 3'd1, 1'b0, V_NONE, V_NONE, 10'b0000000001);
        instr("jmp", 3'd7, 1'b0, V_NONE, 10'b0000100000, 10'b0000100001);

        // Stall at phase 0, release, then drop run mid-instruction.
        opcode = 3'd2;
        run    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick; chk("stall_hold", V_P0);
        end
        run = 1'b1;
        tick; chk("stall_rel_p1", V_P1);
        tick; chk("stall_p2", V_P23);
        tick; chk("stall_p3", V_P23);
        run = 1'b0;
        tick; chk("drop_p4", V_P4);
        tick; chk("drop_p5", 10'b0100000000);
        tick; chk("drop_p6", 10'b0100000000);
        tick; chk("drop_p7", 10'b0100010001);
        tick; chk("drop_p0", V_P0);
        exp_ret++;
        chk_ret("drop_ret");
        tick; chk("drop_held", V_P0);
        tick; chk("drop_held2", V_P0);
        run = 1'b1;

        // 6 retired so far; 11 more gives 17, i.e. 1 on the 4-bit counter.
        for (int i = 0; i < 11; i++) begin
            instr("wrap", 3'd5, 1'b0, 10'b0100000000, 10'b0100000000, 10'b0100010001);
        end
        n_tests++;
        assert (retired4 === 4'd1 && retired === 16'd17)
        else begin
            n_fail++;
            $error("FAIL wrap17: got %0d/%0d required 1/17", retired4, retired);
        end

        // Reset during phase 6 of a store: no write strobe follows.
        opcode = 3'd6;
        chk("rst6_p0", V_P0);
        for (int i = 0; i < 6; i++) tick;
        chk("rst6_p6", 10'b0000001000);
        rst = 1'b1;
        tick; chk("rst6_after", V_P0);
        exp_ret = 0;
        chk_ret("rst6_ret");
        rst = 1'b0;

        // Halt: sticky for 20 cycles, cleared only by reset.
        opcode = 3'd0;
        tick; chk("hlt_p1", V_P1);
        tick; chk("hlt_p2", V_P23);
        tick; chk("hlt_p3", V_P23);
        tick; chk("hlt_p4", V_P4H);
        for (int i = 0; i < 20; i++) begin
            tick; chk("hlt_sticky", V_HALT);
        end
        chk_ret("hlt_ret");
        rst = 1'b1;
        tick; chk("hlt_rst", V_P0);
        rst = 1'b0;
        tick; chk("hlt_restart_p1", V_P1);

        // Reset coinciding with HLT decode wins.
        tick; tick; tick; chk("hltrst_p4", V_P4H);
        rst = 1'b1;
        tick; chk("hltrst_p0", V_P0);
        run = 1'b0;
        tick; chk("rstrun0_p0", V_P0);
        rst = 1'b0;
        tick; chk("rstrun0_hold", V_P0);
        run = 1'b1;
        tick; chk("rstrun0_rel", V_P1);
        chk_ret("final_ret");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
